// File: rtl/vrf_write_addr_gen.sv
// vrf_write_addr_gen
// Turns a stream of result elements for one lane into VRF write transactions.
// A load captures the base address of each of the 8 registers in the group,
// the element width and the element count. Each accepted element produces one
// registered write: the address is the current register's base plus the word
// offset of the element, the data is replicated across the 32-bit word and
// the byte enables select the element's lanes inside that word.
//
// Ports
//   clk_i, rst_i        clock, synchronous active-high reset
//   start_addr_i        8 packed base addresses, slot k at [k*AW +: AW]
//   vl_i                number of elements this lane writes
//   element_width_i     00 byte, 01 halfword, 10 word, 11 illegal
//   load_i              start-of-instruction strobe
//   data_valid_i/data_i result element handshake (ready_o = ACTIVE)
//   wvalid_o, waddr_o, wdata_o, bwe_o   VRF write port
//   done_o              one-cycle end-of-instruction pulse
//   err_o               one-cycle illegal-load pulse
//
// state  | meaning
// IDLE   | no instruction in flight, elements ignored
// ACTIVE | accepting elements until vl have been written
// DONE   | last write on the port, done_o high for this cycle
module vrf_write_addr_gen #(
   parameter  int MEM_DEPTH         = 512,
   parameter  int VREG_LOC_PER_LANE = 8,
   localparam int AW                = $clog2(MEM_DEPTH),
   localparam int CW                = $clog2(4*VREG_LOC_PER_LANE),
   localparam int VLW               = $clog2(32*VREG_LOC_PER_LANE) + 1
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic [8*AW-1:0] start_addr_i,
   input  logic [VLW-1:0]  vl_i,
   input  logic [1:0]      element_width_i,
   input  logic            load_i,
   input  logic            data_valid_i,
   input  logic [31:0]     data_i,
   output logic            ready_o,
   output logic            wvalid_o,
   output logic [AW-1:0]   waddr_o,
   output logic [31:0]     wdata_o,
   output logic [3:0]      bwe_o,
   output logic            done_o,
   output logic            err_o
);

   localparam int LIM_B = 4*VREG_LOC_PER_LANE - 1;
   localparam int LIM_H = 2*VREG_LOC_PER_LANE - 1;
   localparam int LIM_W = VREG_LOC_PER_LANE - 1;

   typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

   state_t          state_q, state_d;
   logic [AW-1:0]   base_q [8];
   logic [AW-1:0]   base_d [8];
   logic [1:0]      sew_q, sew_d;
   logic [VLW-1:0]  vl_q, vl_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [2:0]      reg_idx_q, reg_idx_d;
   logic [VLW-1:0]  acc_q, acc_d;
   logic            wvalid_q, wvalid_d;
   logic [AW-1:0]   waddr_q, waddr_d;
   logic [31:0]     wdata_q, wdata_d;
   logic [3:0]      bwe_q, bwe_d;
   logic            err_q, err_d;

   logic [CW-1:0]   limit_cur;
   logic [CW-1:0]   offset;
   logic [VLW:0]    vl_max_load;
   logic            load_legal;

   // Element count capacity of the whole 8-register group for the incoming width.
   always_comb begin
      case (element_width_i)
         2'b00:   vl_max_load = (VLW+1)'(8*(LIM_B+1));
         2'b01:   vl_max_load = (VLW+1)'(8*(LIM_H+1));
         default: vl_max_load = (VLW+1)'(8*(LIM_W+1));
      endcase
   end

   assign load_legal = (element_width_i != 2'b11) && ({1'b0, vl_i} <= vl_max_load);

   // Element counter runs over one register; offset is its word index.
   always_comb begin
      case (sew_q)
         2'b00: begin
            limit_cur = CW'(LIM_B);
            offset    = cnt_q >> 2;
         end
         2'b01: begin
            limit_cur = CW'(LIM_H);
            offset    = cnt_q >> 1;
         end
         default: begin
            limit_cur = CW'(LIM_W);
            offset    = cnt_q;
         end
      endcase
   end

   always_comb begin
      state_d   = state_q;
      base_d    = base_q;
      sew_d     = sew_q;
      vl_d      = vl_q;
      cnt_d     = cnt_q;
      reg_idx_d = reg_idx_q;
      acc_d     = acc_q;
      wvalid_d  = 1'b0;
      waddr_d   = waddr_q;
      wdata_d   = wdata_q;
      bwe_d     = bwe_q;
      err_d     = 1'b0;

      if (load_i) begin
         // A load wins over a concurrent element; that element is dropped.
         if (load_legal) begin
            for (int k = 0; k < 8; k++) begin
               base_d[k] = start_addr_i[k*AW +: AW];
            end
            sew_d     = element_width_i;
            vl_d      = vl_i;
            cnt_d     = '0;
            reg_idx_d = '0;
            acc_d     = '0;
            state_d   = (vl_i == '0) ? DONE : ACTIVE;
         end else begin
            err_d   = 1'b1;
            state_d = IDLE;
         end
      end else begin
         case (state_q)
            ACTIVE: begin
               if (data_valid_i) begin
                  wvalid_d = 1'b1;
                  waddr_d  = base_q[reg_idx_q] + AW'(offset);
                  case (sew_q)
                     2'b00: begin
                        wdata_d = {4{data_i[7:0]}};
                        bwe_d   = 4'b0001 << cnt_q[1:0];
                     end
                     2'b01: begin
                        wdata_d = {2{data_i[15:0]}};
                        bwe_d   = 4'b0011 << {cnt_q[0], 1'b0};
                     end
                     default: begin
                        wdata_d = data_i;
                        bwe_d   = 4'hF;
                     end
                  endcase
                  if (cnt_q == limit_cur) begin
                     cnt_d     = '0;
                     reg_idx_d = reg_idx_q + 3'd1;
                  end else begin
                     cnt_d = cnt_q + CW'(1);
                  end
                  acc_d = acc_q + VLW'(1);
                  if (acc_d == vl_q) begin
                     state_d = DONE;
                  end
               end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= IDLE;
         for (int k = 0; k < 8; k++) begin
            base_q[k] <= '0;
         end
         sew_q     <= '0;
         vl_q      <= '0;
         cnt_q     <= '0;
         reg_idx_q <= '0;
         acc_q     <= '0;
         wvalid_q  <= 1'b0;
         waddr_q   <= '0;
         wdata_q   <= '0;
         bwe_q     <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         base_q    <= base_d;
         sew_q     <= sew_d;
         vl_q      <= vl_d;
         cnt_q     <= cnt_d;
         reg_idx_q <= reg_idx_d;
         acc_q     <= acc_d;
         wvalid_q  <= wvalid_d;
         waddr_q   <= waddr_d;
         wdata_q   <= wdata_d;
         bwe_q     <= bwe_d;
         err_q     <= err_d;
      end
   end

   assign ready_o  = (state_q == ACTIVE);
   assign done_o   = (state_q == DONE);
   assign wvalid_o = wvalid_q;
   assign waddr_o  = waddr_q;
   assign wdata_o  = wdata_q;
   assign bwe_o    = bwe_q;
   assign err_o    = err_q;

endmodule

// File: tb/tb_vrf_write_addr_gen.sv
// Directed bench for vrf_write_addr_gen with default parameters
// (AW = 9, VLW = 9). Inputs change 1 ns after each rising edge and outputs
// are sampled at that same point, so every check sees the result of the
// edge just taken.
module tb_vrf_write_addr_gen;

   localparam int AW  = 9;
   localparam int VLW = 9;

   logic            clk_i = 1'b0;
   logic            rst_i;
   logic [8*AW-1:0] start_addr_i;
   logic [VLW-1:0]  vl_i;
   logic [1:0]      element_width_i;
   logic            load_i;
   logic            data_valid_i;
   logic [31:0]     data_i;
   logic            ready_o;
   logic            wvalid_o;
   logic [AW-1:0]   waddr_o;
   logic [31:0]     wdata_o;
   logic [3:0]      bwe_o;
   logic            done_o;
   logic            err_o;

   int n_pass  = 0;
   int n_total = 0;

   vrf_write_addr_gen dut (
      .clk_i           (clk_i),
      .rst_i           (rst_i),
      .start_addr_i    (start_addr_i),
      .vl_i            (vl_i),
      .element_width_i (element_width_i),
      .load_i          (load_i),
      .data_valid_i    (data_valid_i),
      .data_i          (data_i),
      .ready_o         (ready_o),
      .wvalid_o        (wvalid_o),
      .waddr_o         (waddr_o),
      .wdata_o         (wdata_o),
      .bwe_o           (bwe_o),
      .done_o          (done_o),
      .err_o           (err_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic idle_inputs();
      load_i       = 1'b0;
      data_valid_i = 1'b0;
      data_i       = '0;
   endtask

   // Issue a load with bases b0/b1 (other slots 0), then leave inputs idle.
   task automatic do_load(input logic [1:0] ew, input int vl, input int b0, input int b1);
      start_addr_i            = '0;
      start_addr_i[0*AW +: AW] = AW'(b0);
      start_addr_i[1*AW +: AW] = AW'(b1);
      element_width_i         = ew;
      vl_i                    = VLW'(vl);
      load_i                  = 1'b1;
      data_valid_i            = 1'b0;
      tick();
      idle_inputs();
   endtask

   // Present one element and check the write it produces.
   task automatic beat(input string tag, input logic [31:0] d, input int addr,
                       input logic [31:0] wd, input logic [3:0] be, input logic dn);
      data_valid_i = 1'b1;
      data_i       = d;
      tick();
      data_valid_i = 1'b0;
      chk({tag, ".wvalid"}, 64'(wvalid_o), 64'd1);
      chk({tag, ".waddr"},  64'(waddr_o),  64'(addr));
      chk({tag, ".wdata"},  64'(wdata_o),  64'(wd));
      chk({tag, ".bwe"},    64'(bwe_o),    64'(be));
      chk({tag, ".done"},   64'(done_o),   64'(dn));
   endtask

   initial begin
      rst_i           = 1'b1;
      start_addr_i    = '0;
      vl_i            = '0;
      element_width_i = 2'b10;
      idle_inputs();
      tick();
      tick();
      chk("rst.ready",  64'(ready_o),  64'd0);
      chk("rst.wvalid", 64'(wvalid_o), 64'd0);
      chk("rst.waddr",  64'(waddr_o),  64'd0);
      chk("rst.wdata",  64'(wdata_o),  64'd0);
      chk("rst.bwe",    64'(bwe_o),    64'd0);
      chk("rst.done",   64'(done_o),   64'd0);
      chk("rst.err",    64'(err_o),    64'd0);
      rst_i = 1'b0;
      tick();

      // Word, base 16, three back-to-back elements.
      do_load(2'b10, 3, 16, 0);
      chk("w.ready", 64'(ready_o), 64'd1);
      beat("w0", 32'hA, 16, 32'hA, 4'hF, 1'b0);
      beat("w1", 32'hB, 17, 32'hB, 4'hF, 1'b0);
      beat("w2", 32'hC, 18, 32'hC, 4'hF, 1'b1);
      tick();
      chk("w.post.wvalid", 64'(wvalid_o), 64'd0);
      chk("w.post.done",   64'(done_o),   64'd0);
      chk("w.post.ready",  64'(ready_o),  64'd0);
      chk("w.post.waddr",  64'(waddr_o),  64'd18);

      // Byte, base 40: four bytes fill word 40, fifth starts word 41.
      do_load(2'b00, 5, 40, 0);
      beat("b0", 32'hFF11, 40, 32'h11111111, 4'b0001, 1'b0);
      beat("b1", 32'h22,   40, 32'h22222222, 4'b0010, 1'b0);
      beat("b2", 32'h33,   40, 32'h33333333, 4'b0100, 1'b0);
      beat("b3", 32'h44,   40, 32'h44444444, 4'b1000, 1'b0);
      beat("b4", 32'h55,   41, 32'h55555555, 4'b0001, 1'b1);
      tick();

      // Halfword, base 8: two halves per word.
      do_load(2'b01, 3, 8, 0);
      beat("h0", 32'hABCD1234, 8, 32'h12341234, 4'b0011, 1'b0);
      beat("h1", 32'h5678,     8, 32'h56785678, 4'b1100, 1'b0);
      beat("h2", 32'h9ABC,     9, 32'h9ABC9ABC, 4'b0011, 1'b1);
      tick();

      // Word crossing into register 1 after 8 locations.
      do_load(2'b10, 10, 0, 100);
      for (int i = 0; i < 10; i++) begin
         beat($sformatf("x%0d", i), 32'(i + 1), (i < 8) ? i : 92 + i,
              32'(i + 1), 4'hF, (i == 9));
      end
      tick();

      // Gap between elements: no write, outputs hold.
      do_load(2'b10, 2, 200, 0);
      beat("g0", 32'h77, 200, 32'h77, 4'hF, 1'b0);
      tick();
      chk("gap.wvalid", 64'(wvalid_o), 64'd0);
      chk("gap.wdata",  64'(wdata_o),  64'h77);
      beat("g1", 32'h88, 201, 32'h88, 4'hF, 1'b1);
      tick();

      // vl = 0: done next cycle, never ready, no writes.
      do_load(2'b10, 0, 5, 0);
      chk("vl0.done",   64'(done_o),   64'd1);
      chk("vl0.ready",  64'(ready_o),  64'd0);
      chk("vl0.wvalid", 64'(wvalid_o), 64'd0);
      tick();
      chk("vl0.done2",  64'(done_o),   64'd0);
      chk("vl0.ready2", 64'(ready_o),  64'd0);

      // Load with a concurrent element: element dropped.
      do_load(2'b10, 4, 300, 0);
      start_addr_i             = '0;
      start_addr_i[0*AW +: AW] = AW'(50);
      vl_i                     = VLW'(2);
      load_i                   = 1'b1;
      data_valid_i             = 1'b1;
      data_i                   = 32'hDEAD;
      tick();
      idle_inputs();
      chk("lp.wvalid", 64'(wvalid_o), 64'd0);
      chk("lp.ready",  64'(ready_o),  64'd1);
      beat("lp0", 32'h1, 50, 32'h1, 4'hF, 1'b0);

      // Reset mid-instruction wins over load and kills progress.
      do_load(2'b10, 5, 16, 0);
      beat("r0", 32'h10, 16, 32'h10, 4'hF, 1'b0);
      beat("r1", 32'h20, 17, 32'h20, 4'hF, 1'b0);
      rst_i        = 1'b1;
      load_i       = 1'b1;
      data_valid_i = 1'b1;
      tick();
      idle_inputs();
      chk("rm.ready",  64'(ready_o),  64'd0);
      chk("rm.wvalid", 64'(wvalid_o), 64'd0);
      chk("rm.waddr",  64'(waddr_o),  64'd0);
      chk("rm.wdata",  64'(wdata_o),  64'd0);
      chk("rm.bwe",    64'(bwe_o),    64'd0);
      rst_i        = 1'b0;
      data_valid_i = 1'b1;
      tick();
      data_valid_i = 1'b0;
      chk("rm.idle.wvalid", 64'(wvalid_o), 64'd0);
      do_load(2'b10, 1, 16, 0);
      beat("rm.new", 32'h99, 16, 32'h99, 4'hF, 1'b1);
      tick();

      // Illegal loads.
      do_load(2'b11, 3, 0, 0);
      chk("e11.err",   64'(err_o),   64'd1);
      chk("e11.ready", 64'(ready_o), 64'd0);
      tick();
      chk("e11.err2",  64'(err_o),   64'd0);
      do_load(2'b10, 65, 0, 0);
      chk("e65.err",   64'(err_o),   64'd1);
      chk("e65.ready", 64'(ready_o), 64'd0);
      data_valid_i = 1'b1;
      tick();
      data_valid_i = 1'b0;
      chk("e65.wvalid", 64'(wvalid_o), 64'd0);
      do_load(2'b10, 64, 0, 0);
      chk("w64.err",   64'(err_o),   64'd0);
      chk("w64.ready", 64'(ready_o), 64'd1);
      do_load(2'b00, 256, 0, 0);
      chk("b256.err",   64'(err_o),   64'd0);
      chk("b256.ready", 64'(ready_o), 64'd1);
      do_load(2'b01, 129, 0, 0);
      chk("h129.err",   64'(err_o),   64'd1);
      chk("h129.ready", 64'(ready_o), 64'd0);
      tick();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
